// File: rtl/cl_matvec_pkg.sv
// Shared types and constants for the DRAM matrix-vector engine.
package cl_matvec_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StVecAr,
    StVecR,
    StRowAr,
    StRowR,
    StMac,
    StAwW,
    StB,
    StFin
  } state_e;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExokay = 2'b01,
    RespSlverr = 2'b10,
    RespDecerr = 2'b11
  } axi_resp_e;

  localparam logic [7:0] RegCtrl   = 8'h00;
  localparam logic [7:0] RegStatus = 8'h04;
  localparam logic [7:0] RegRows   = 8'h08;
  localparam logic [7:0] RegMatLo  = 8'h10;
  localparam logic [7:0] RegMatHi  = 8'h14;
  localparam logic [7:0] RegVecLo  = 8'h18;
  localparam logic [7:0] RegVecHi  = 8'h1C;
  localparam logic [7:0] RegDstLo  = 8'h20;
  localparam logic [7:0] RegDstHi  = 8'h24;
  localparam logic [7:0] RegPerf   = 8'h28;

  localparam int unsigned AccW = 64;

  function automatic int unsigned idx_w(int unsigned dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  // Any response other than OKAY is treated as an error, EXOKAY included.
  function automatic logic resp_err(logic [1:0] resp);
    return resp != RespOkay;
  endfunction

endpackage

// File: rtl/cl_matvec_mac.sv
// Single-lane multiply-accumulate: one element of the row per enabled cycle.
module cl_matvec_mac
  import cl_matvec_pkg::*;
#(
  parameter int unsigned DIM    = 16,
  parameter int unsigned ELEM_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     signed_mode,
  input  logic [idx_w(DIM)-1:0]    idx,
  input  logic [DIM*ELEM_W-1:0]    a_vec,
  input  logic [DIM*ELEM_W-1:0]    x_vec,
  output logic [AccW-1:0]          acc,
  output logic                     last
);

  localparam int unsigned IdxW = idx_w(DIM);

  logic [ELEM_W-1:0] a_el;
  logic [ELEM_W-1:0] x_el;
  logic [AccW-1:0]   a_ext;
  logic [AccW-1:0]   x_ext;
  logic [AccW-1:0]   prod;

  assign a_el = a_vec[idx*ELEM_W +: ELEM_W];
  assign x_el = x_vec[idx*ELEM_W +: ELEM_W];

  // Low 64 bits of the extended product equal the product modulo 2^64 in either mode.
  assign a_ext = {{(AccW-ELEM_W){signed_mode & a_el[ELEM_W-1]}}, a_el};
  assign x_ext = {{(AccW-ELEM_W){signed_mode & x_el[ELEM_W-1]}}, x_el};
  assign prod  = a_ext * x_ext;

  assign last = en && (idx == IdxW'(DIM - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + prod;
    end
  end

endmodule

// File: rtl/cl_dram_matvec_engine.sv
// Matrix-vector engine: dst[r] = sum_k A[r][k]*x[k], operands and results over AXI4.
// Optional build macro MATVEC_PERF_CNT_EN adds a busy-cycle counter at 0x28.
module cl_dram_matvec_engine
  import cl_matvec_pkg::*;
#(
  parameter int unsigned DIM    = 16,
  parameter int unsigned ELEM_W = 32,
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned ROW_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         cfg_addr,
  input  logic [31:0]         cfg_wdata,
  input  logic                cfg_wr,
  input  logic                cfg_rd,
  output logic                cfg_ack,
  output logic [31:0]         cfg_rdata,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  input  logic                rvalid,
  output logic                rready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  output logic                done_irq
);

  localparam int unsigned OpW       = DIM * ELEM_W;
  localparam int unsigned BeatBytes = DATA_W / 8;
  localparam int unsigned IdxW      = idx_w(DIM);

  state_e            state_q;
  logic [ROW_W-1:0]  rows_reg, job_rows, row_idx, rows_done;
  logic [31:0]       mat_lo, mat_hi, vec_lo, vec_hi, dst_lo, dst_hi;
  logic [63:0]       mat_full, vec_full, dst_full;
  logic [ADDR_W-1:0] row_addr, dst_addr;
  logic              signed_q, busy, done, err;
  logic [OpW-1:0]    a_q, x_q;
  logic [IdxW-1:0]   mac_idx;
  logic [AccW-1:0]   acc;
  logic              mac_last, mac_clr, mac_en;
  logic [7:0]        reg_addr;
  logic              start;
  logic [31:0]       perf_cnt, rd_mux, rows_done_w;
  logic [2:0]        w_lane;
  logic              unused_bits;

  assign reg_addr    = cfg_addr[7:0];
  assign start       = cfg_wr && (reg_addr == RegCtrl) && cfg_wdata[0] && (state_q == StIdle);
  assign mat_full    = {mat_hi, mat_lo};
  assign vec_full    = {vec_hi, vec_lo};
  assign dst_full    = {dst_hi, dst_lo};
  assign rows_done_w = 32'(rows_done);
  assign unused_bits = ^{cfg_addr[31:8], rlast, rdata};

  assign arlen  = 8'd0;
  assign arsize = 3'($clog2(BeatBytes));
  assign awlen  = 8'd0;
  assign awsize = 3'd3;
  assign wlast  = 1'b1;

  // Result sits in the 64-bit lane selected by the write address.
  assign w_lane = awaddr[5:3];
  assign wdata  = {{(DATA_W-AccW){1'b0}}, acc} << {w_lane, 6'd0};
  assign wstrb  = {{(DATA_W/8-8){1'b0}}, 8'hFF} << {w_lane, 3'd0};

  assign mac_clr = (state_q == StRowR) && rvalid;
  assign mac_en  = (state_q == StMac);

  cl_matvec_mac #(
    .DIM    (DIM),
    .ELEM_W (ELEM_W)
  ) u_mac (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (mac_clr),
    .en          (mac_en),
    .signed_mode (signed_q),
    .idx         (mac_idx),
    .a_vec       (a_q),
    .x_vec       (x_q),
    .acc         (acc),
    .last        (mac_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_reg <= '0;
      mat_lo   <= '0;
      mat_hi   <= '0;
      vec_lo   <= '0;
      vec_hi   <= '0;
      dst_lo   <= '0;
      dst_hi   <= '0;
    end else if (cfg_wr) begin
      case (reg_addr)
        RegRows:  rows_reg <= ROW_W'(cfg_wdata);
        RegMatLo: mat_lo   <= cfg_wdata;
        RegMatHi: mat_hi   <= cfg_wdata;
        RegVecLo: vec_lo   <= cfg_wdata;
        RegVecHi: vec_hi   <= cfg_wdata;
        RegDstLo: dst_lo   <= cfg_wdata;
        RegDstHi: dst_hi   <= cfg_wdata;
        default:  ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      RegStatus: rd_mux = {rows_done_w[15:0], 13'd0, err, done, busy};
      RegRows:   rd_mux = 32'(rows_reg);
      RegMatLo:  rd_mux = mat_lo;
      RegMatHi:  rd_mux = mat_hi;
      RegVecLo:  rd_mux = vec_lo;
      RegVecHi:  rd_mux = vec_hi;
      RegDstLo:  rd_mux = dst_lo;
      RegDstHi:  rd_mux = dst_hi;
      RegPerf:   rd_mux = perf_cnt;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ack   <= 1'b0;
      cfg_rdata <= '0;
    end else begin
      cfg_ack <= cfg_wr | cfg_rd;
      if (cfg_rd) begin
        cfg_rdata <= rd_mux;
      end
    end
  end

`ifdef MATVEC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt <= '0;
    end else if (start) begin
      perf_cnt <= '0;
    end else if (busy && (perf_cnt != '1)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end
`else
  assign perf_cnt = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      arvalid   <= 1'b0;
      araddr    <= '0;
      rready    <= 1'b0;
      awvalid   <= 1'b0;
      awaddr    <= '0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      done_irq  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rows_done <= '0;
      row_idx   <= '0;
      job_rows  <= '0;
      signed_q  <= 1'b0;
      row_addr  <= '0;
      dst_addr  <= '0;
      a_q       <= '0;
      x_q       <= '0;
      mac_idx   <= '0;
    end else begin
      done_irq <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            row_addr  <= mat_full[ADDR_W-1:0];
            dst_addr  <= dst_full[ADDR_W-1:0];
            job_rows  <= rows_reg;
            signed_q  <= cfg_wdata[1];
            row_idx   <= '0;
            rows_done <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b1;
            if (rows_reg == '0) begin
              state_q <= StFin;
            end else begin
              arvalid <= 1'b1;
              araddr  <= vec_full[ADDR_W-1:0];
              state_q <= StVecAr;
            end
          end
        end
        StVecAr: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_q <= StVecR;
          end
        end
        StVecR: begin
          if (rvalid) begin
            x_q     <= rdata[OpW-1:0];
            err     <= err | resp_err(rresp);
            rready  <= 1'b0;
            arvalid <= 1'b1;
            araddr  <= row_addr;
            state_q <= StRowAr;
          end
        end
        StRowAr: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_q <= StRowR;
          end
        end
        StRowR: begin
          if (rvalid) begin
            a_q      <= rdata[OpW-1:0];
            err      <= err | resp_err(rresp);
            rready   <= 1'b0;
            row_addr <= row_addr + ADDR_W'(BeatBytes);
            mac_idx  <= '0;
            state_q  <= StMac;
          end
        end
        StMac: begin
          mac_idx <= mac_idx + 1'b1;
          if (mac_last) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= dst_addr;
            state_q <= StAwW;
          end
        end
        StAwW: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          // Move on once both channels have fired, in this cycle or earlier.
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready  <= 1'b1;
            state_q <= StB;
          end
        end
        StB: begin
          if (bvalid) begin
            bready    <= 1'b0;
            err       <= err | resp_err(bresp);
            rows_done <= rows_done + 1'b1;
            row_idx   <= row_idx + 1'b1;
            dst_addr  <= dst_addr + ADDR_W'(8);
            if (row_idx + 1'b1 == job_rows) begin
              state_q <= StFin;
            end else begin
              arvalid <= 1'b1;
              araddr  <= row_addr;
              state_q <= StRowAr;
            end
          end
        end
        StFin: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          done_irq <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_dram_matvec_engine.sv
// Directed bench for cl_dram_matvec_engine with a small AXI slave memory model.
module tb_cl_dram_matvec_engine;

  localparam int DATA_W = 512;
  localparam int ADDR_W = 64;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [31:0]         cfg_addr = '0;
  logic [31:0]         cfg_wdata = '0;
  logic                cfg_wr = 1'b0;
  logic                cfg_rd = 1'b0;
  logic                cfg_ack;
  logic [31:0]         cfg_rdata;
  logic                arvalid;
  logic                arready = 1'b1;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic                rvalid = 1'b0;
  logic                rready;
  logic [DATA_W-1:0]   rdata = '0;
  logic [1:0]          rresp = 2'b00;
  logic                rlast = 1'b1;
  logic                awvalid;
  logic                awready = 1'b1;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic                wvalid;
  logic                wready = 1'b1;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                bvalid = 1'b0;
  logic                bready;
  logic [1:0]          bresp = 2'b00;
  logic                done_irq;

  always #5 clk = ~clk;

  cl_dram_matvec_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_wr    (cfg_wr),
    .cfg_rd    (cfg_rd),
    .cfg_ack   (cfg_ack),
    .cfg_rdata (cfg_rdata),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .arlen     (arlen),
    .arsize    (arsize),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .bvalid    (bvalid),
    .bready    (bready),
    .bresp     (bresp),
    .done_irq  (done_irq)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave model state: handshakes sampled on posedge, responses driven on negedge.
  logic [DATA_W-1:0] rmem [logic [63:0]];
  logic [63:0]       ar_q[$];
  logic [63:0]       ar_log[$];
  logic [63:0]       aw_log[$];
  logic [DATA_W-1:0] w_log[$];
  logic [63:0]       strb_log[$];
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, b_issued = 0, r_served = 0;
  int r_allow = 1 << 30;
  int slverr_idx = -1;
  bit aw_delay = 1'b0;
  int flush_gen = 0;

  always begin : slave
    int aw_wait;
    int flush_seen;
    bit r_taken, b_taken;
    logic [63:0] a;
    aw_wait = 5;
    flush_seen = 0;
    r_taken = 1'b0;
    b_taken = 1'b0;
    forever begin
      @(posedge clk);
      if (rst_n) begin
        if (arvalid && arready) begin
          ar_cnt++;
          ar_q.push_back(araddr);
          ar_log.push_back(araddr);
        end
        if (rvalid && rready) r_taken = 1'b1;
        if (awvalid && awready) begin
          aw_cnt++;
          aw_log.push_back(awaddr);
        end
        if (wvalid && wready) begin
          w_cnt++;
          w_log.push_back(wdata);
          strb_log.push_back(wstrb);
        end
        if (bvalid && bready) b_taken = 1'b1;
      end
      @(negedge clk);
      if (flush_seen != flush_gen) begin
        flush_seen = flush_gen;
        ar_q.delete();
        rvalid = 1'b0;
        r_taken = 1'b0;
      end
      if (r_taken) begin
        rvalid = 1'b0;
        r_taken = 1'b0;
      end
      if (!rvalid && ar_q.size() > 0 && r_served < r_allow) begin
        a = ar_q.pop_front();
        rvalid = 1'b1;
        rdata = rmem.exists(a) ? rmem[a] : '0;
        r_served++;
      end
      if (b_taken) begin
        bvalid = 1'b0;
        b_taken = 1'b0;
      end
      if (!bvalid && aw_cnt > b_issued && w_cnt > b_issued) begin
        bvalid = 1'b1;
        bresp = (b_issued == slverr_idx) ? 2'b10 : 2'b00;
        b_issued++;
      end
      if (aw_delay) begin
        if (w_cnt > aw_cnt) begin
          if (aw_wait == 0) awready = 1'b1;
          else aw_wait--;
        end else begin
          awready = 1'b0;
          aw_wait = 5;
        end
      end else begin
        awready = 1'b1;
      end
    end
  end

  function automatic logic [DATA_W-1:0] beat_lin(input int base, input int step);
    logic [DATA_W-1:0] b;
    b = '0;
    for (int k = 0; k < 16; k++) b[32*k +: 32] = 32'(base + step * k);
    return b;
  endfunction

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    cfg_addr = {24'd0, a};
    cfg_wdata = d;
    cfg_wr = 1'b1;
    @(negedge clk);
    cfg_wr = 1'b0;
  endtask

  logic last_ack;
  task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
    cfg_addr = {24'd0, a};
    cfg_rd = 1'b1;
    @(negedge clk);
    cfg_rd = 1'b0;
    d = cfg_rdata;
    last_ack = cfg_ack;
  endtask

  task automatic program_job(input logic [31:0] mat, input logic [31:0] vec,
                             input logic [31:0] dst, input logic [31:0] rows);
    cfg_write(8'h10, mat);
    cfg_write(8'h14, 32'd0);
    cfg_write(8'h18, vec);
    cfg_write(8'h1C, 32'd0);
    cfg_write(8'h20, dst);
    cfg_write(8'h24, 32'd0);
    cfg_write(8'h08, rows);
  endtask

  task automatic start_job(input bit sgn);
    cfg_write(8'h00, {30'd0, sgn, 1'b1});
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!done_irq && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, done_irq, 1'b1);
    @(negedge clk);
    check({tag, "_pulse_drop"}, done_irq, 1'b0);
  endtask

  task automatic check_write(input string tag, input int i, input logic [63:0] addr,
                             input logic [63:0] val);
    logic [DATA_W-1:0] w;
    int lane;
    lane = int'(addr[5:3]);
    check({tag, "_awaddr"}, (i < aw_log.size()) ? aw_log[i] : 64'hDEAD, addr);
    w = (i < w_log.size()) ? (w_log[i] >> (64 * lane)) : '0;
    check({tag, "_wdata"}, w[63:0], val);
    check({tag, "_wstrb"}, (i < strb_log.size()) ? strb_log[i] : 64'd0, 64'hFF << (8 * lane));
  endtask

  initial begin
    logic [31:0] rd;
    int cyc, ar0, aw0, w0;

    repeat (3) @(negedge clk);
    check("rst_outputs", {arvalid, awvalid, wvalid, rready, bready, done_irq, cfg_ack}, 7'd0);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_read(8'h04, rd);
    check("rst_status", rd, 32'd0);
    check("cfg_ack", last_ack, 1'b1);

    // Job 1: one row, A = 1..16, x = 2, unsigned -> 0x110
    rmem[64'h10000] = beat_lin(1, 1);
    rmem[64'h20000] = beat_lin(2, 0);
    program_job(32'h10000, 32'h20000, 32'h2000, 32'd1);
    aw0 = aw_cnt;
    start_job(1'b0);
    wait_done("j1_done", cyc);
    check("j1_aw_count", aw_cnt - aw0, 1);
    check_write("j1_row0", aw0, 64'h2000, 64'h110);
    cfg_read(8'h04, rd);
    check("j1_status", rd, 32'h0001_0002);
    cfg_read(8'h28, rd);
`ifdef MATVEC_PERF_CNT_EN
    check("perf_nonzero", rd != 0, 1'b1);
`else
    check("perf_absent", rd, 32'd0);
`endif
    cfg_read(8'h3C, rd);
    check("unmapped_read", rd, 32'd0);

    // Job 2: three rows, signed, A = -1, x[k] = k -> -120 at 0x1008/0x1010/0x1018
    rmem[64'h10000] = beat_lin(-1, 0);
    rmem[64'h10040] = beat_lin(-1, 0);
    rmem[64'h10080] = beat_lin(-1, 0);
    rmem[64'h20000] = beat_lin(0, 1);
    program_job(32'h10000, 32'h20000, 32'h1008, 32'd3);
    ar0 = ar_cnt;
    aw0 = aw_cnt;
    start_job(1'b1);
    wait_done("j2_done", cyc);
    check("j2_ar_count", ar_cnt - ar0, 4);
    check("j2_row2_araddr", (ar0 + 3 < ar_log.size()) ? ar_log[ar0 + 3] : 64'd0, 64'h10080);
    check("j2_aw_count", aw_cnt - aw0, 3);
    check_write("j2_row0", aw0, 64'h1008, 64'hFFFF_FFFF_FFFF_FF88);
    check_write("j2_row1", aw0 + 1, 64'h1010, 64'hFFFF_FFFF_FFFF_FF88);
    check_write("j2_row2", aw0 + 2, 64'h1018, 64'hFFFF_FFFF_FFFF_FF88);
    cfg_read(8'h04, rd);
    check("j2_status", rd, 32'h0003_0002);

    // Job 3: zero rows -> immediate done, no AXI traffic
    cfg_write(8'h08, 32'd0);
    ar0 = ar_cnt;
    aw0 = aw_cnt;
    start_job(1'b0);
    wait_done("j3_done", cyc);
    check("j3_latency_le3", cyc <= 3, 1'b1);
    check("j3_no_ar", ar_cnt - ar0, 0);
    check("j3_no_aw", aw_cnt - aw0, 0);
    cfg_read(8'h04, rd);
    check("j3_status", rd, 32'h0000_0002);

    // Job 4: awready held off until well after the W beat
    rmem[64'h10000] = beat_lin(1, 1);
    rmem[64'h10040] = beat_lin(3, 0);
    rmem[64'h20000] = beat_lin(2, 0);
    aw_delay = 1'b1;
    repeat (2) @(negedge clk);
    program_job(32'h10000, 32'h20000, 32'h3000, 32'd2);
    aw0 = aw_cnt;
    w0 = w_cnt;
    start_job(1'b0);
    wait_done("j4_done", cyc);
    check("j4_aw_count", aw_cnt - aw0, 2);
    check("j4_w_count", w_cnt - w0, 2);
    check_write("j4_row0", aw0, 64'h3000, 64'h110);
    check_write("j4_row1", aw0 + 1, 64'h3008, 64'h60);
    aw_delay = 1'b0;
    repeat (2) @(negedge clk);

    // Job 5: SLVERR on the second write response, plus a start while busy
    program_job(32'h10000, 32'h20000, 32'h4000, 32'd2);
    slverr_idx = b_issued + 1;
    ar0 = ar_cnt;
    aw0 = aw_cnt;
    start_job(1'b0);
    cfg_read(8'h04, rd);
    check("j5_busy", {30'd0, rd[1:0]}, 32'd1);
    cfg_write(8'h08, 32'd5);
    start_job(1'b0);
    wait_done("j5_done", cyc);
    check("j5_ar_count", ar_cnt - ar0, 3);
    check("j5_aw_count", aw_cnt - aw0, 2);
    check_write("j5_row0", aw0, 64'h4000, 64'h110);
    check_write("j5_row1", aw0 + 1, 64'h4008, 64'h60);
    cfg_read(8'h04, rd);
    check("j5_status", rd, 32'h0002_0006);
    slverr_idx = -1;

    // Job 6: reset while waiting for a row beat, then a clean job
    program_job(32'h10000, 32'h20000, 32'h5000, 32'd2);
    r_allow = r_served + 1;
    ar0 = ar_cnt;
    start_job(1'b0);
    cyc = 0;
    while (ar_cnt < ar0 + 2 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    repeat (2) @(negedge clk);
    check("j6_in_row_r", rready, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("j6_rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'd0);
    flush_gen++;
    r_allow = 1 << 30;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cfg_read(8'h04, rd);
    check("j6_status_cleared", rd, 32'd0);
    cfg_read(8'h08, rd);
    check("j6_rows_cleared", rd, 32'd0);
    program_job(32'h10000, 32'h20000, 32'h5000, 32'd1);
    aw0 = aw_cnt;
    start_job(1'b0);
    wait_done("j6_done", cyc);
    check("j6_aw_count", aw_cnt - aw0, 1);
    check_write("j6_row0", aw0, 64'h5000, 64'h110);
    cfg_read(8'h04, rd);
    check("j6_status", rd, 32'h0001_0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
